gcd_stein_hs: RTL

//   Parametrised GCD engine using the binary (Stein) algorithm, with start/ready input and

---
 rtl/gcd_stein_hs_if.sv | 40 ++++
 rtl/gcd_stein_hs.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/gcd_stein_hs_if.sv
// Handshake bundle for the binary GCD engine: a start/in_ready request
// channel carrying two operands and a valid/ready result channel carrying
// the GCD and the number of clocks it took.
interface gcd_stein_hs_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [CNT_W-1:0] cycles;

    // Requester side: issues operands, consumes results.
    modport master (
        output start,
        output a_in,
        output b_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out,
        input  cycles
    );

    // Engine side.
    modport slave (
        input  start,
        input  a_in,
        input  b_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out,
        output cycles
    );
endinterface

// File: rtl/gcd_stein_hs.sv
// Binary (Stein) GCD engine with handshaked operand and result channels.
// One algorithm step per clock: SHIFT strips the common power of two, REDUCE
// removes single factors of two and subtracts odd operands until they meet.
// The result is the meeting value shifted back by the common power of two.
// A saturating counter records clocks from accept to the first out_valid
// cycle; out and cycles are held until the next result replaces them.
module gcd_stein_hs #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    gcd_stein_hs_if.slave    bus
);
    localparam int K_W = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_REDUCE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + CNT_W'(1'b1);
        end
        return r;
    endfunction

    // State and datapath registers.
    logic [1:0]       state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [K_W-1:0]   k_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] out_r;
    logic [CNT_W-1:0] cycles_r;
    logic             in_ready_r;
    logic             out_valid_r;

    // Next-state values.
    logic [1:0]       state_s;
    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;
    logic [K_W-1:0]   k_s;
    logic [CNT_W-1:0] cnt_s;
    logic [WIDTH-1:0] out_s;
    logic [CNT_W-1:0] cycles_s;
    logic             in_ready_s;
    logic             out_valid_s;

    logic [CNT_W-1:0] cnt_inc_s;
    logic             a_even_s;
    logic             b_even_s;

    assign cnt_inc_s = sat_inc(cnt_r);
    assign a_even_s  = ~a_r[0];
    assign b_even_s  = ~b_r[0];

    // Controller and datapath next-state: one algorithm step per clock.
    always_comb begin
        state_s     = state_r;
        a_s         = a_r;
        b_s         = b_r;
        k_s         = k_r;
        cnt_s       = cnt_r;
        out_s       = out_r;
        cycles_s    = cycles_r;
        in_ready_s  = in_ready_r;
        out_valid_s = out_valid_r;

        case (state_r)
            ST_IDLE: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
                if (bus.start) begin
                    a_s        = bus.a_in;
                    b_s        = bus.b_in;
                    k_s        = {K_W{1'b0}};
                    cnt_s      = CNT_W'(1'b1);
                    in_ready_s = 1'b0;
                    if (bus.a_in == {WIDTH{1'b0}}) begin
                        // gcd(0, b) = b, which also covers gcd(0, 0) = 0.
                        out_s       = bus.b_in;
                        cycles_s    = CNT_W'(1'b1);
                        out_valid_s = 1'b1;
                        state_s     = ST_DONE;
                    end else if (bus.b_in == {WIDTH{1'b0}}) begin
                        out_s       = bus.a_in;
                        cycles_s    = CNT_W'(1'b1);
                        out_valid_s = 1'b1;
                        state_s     = ST_DONE;
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                cnt_s = cnt_inc_s;
                if (a_even_s && b_even_s) begin
                    a_s = a_r >> 1;
                    b_s = b_r >> 1;
                    k_s = k_r + K_W'(1'b1);
                end else begin
                    state_s = ST_REDUCE;
                end
            end

            ST_REDUCE: begin
                cnt_s = cnt_inc_s;
                if (a_r == b_r) begin
                    // The true gcd fits in WIDTH bits, so the restore shift
                    // never loses set bits.
                    out_s       = a_r << k_r;
                    cycles_s    = cnt_inc_s;
                    out_valid_s = 1'b1;
                    state_s     = ST_DONE;
                end else if (a_even_s) begin
                    a_s = a_r >> 1;
                end else if (b_even_s) begin
                    b_s = b_r >> 1;
                end else if (a_r > b_r) begin
                    // Both odd: the difference is even, halve it at once.
                    a_s = (a_r - b_r) >> 1;
                end else begin
                    b_s = (b_r - a_r) >> 1;
                end
            end

            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_s = 1'b0;
                    in_ready_s  = 1'b1;
                    state_s     = ST_IDLE;
                end else begin
                    out_valid_s = 1'b1;
                    in_ready_s  = 1'b0;
                end
            end

            default: begin
                state_s     = ST_IDLE;
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // State register with asynchronous abort to a clean idle state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            k_r         <= {K_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            out_r       <= {WIDTH{1'b0}};
            cycles_r    <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            a_r         <= a_s;
            b_r         <= b_s;
            k_r         <= k_s;
            cnt_r       <= cnt_s;
            out_r       <= out_s;
            cycles_r    <= cycles_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out       = out_r;
    assign bus.cycles    = cycles_r;
endmodule
